sr_bank: RTL and testbench
==========================

SR_BANK -- requirements
Module: sr_bank

Interface
REQ-001 Parameter WIDTH, default 4, number of independent SR channels (1..32).
REQ-002 Parameter MODE, default 0, response to S=R=1: 0 set-dominant, 1 reset-dominant, 2 hold, 3 toggle.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-004 Parameter CNT_W, default 8, width of the conflict counter.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 s  input  WIDTH  per-channel set request.
REQ-008 r  input  WIDTH  per-channel reset request.
REQ-009 ld  input  1  parallel load strobe.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 clr_conflict  input  1  clears conflict flags and counter.
REQ-012 q  output  WIDTH  registered channel state.
REQ-013 qn  output  WIDTH  bitwise complement of q.
REQ-014 conflict  output  WIDTH  sticky per-channel flag, set when S=R=1 was sampled.
REQ-015 conflict_cnt  output  CNT_W  saturating count of cycles with at least one conflicting channel.

Function
REQ-016 q SHALL update exactly one clock edge after the inputs are sampled; there is no combinational path from s, r, ld or d to q.
REQ-017 qn SHALL equal ~q in every cycle, including during and after reset; q[i]==qn[i] SHALL never occur.
REQ-018 Per channel with ld=0, the next-state rule SHALL be: S=0,R=0 hold; S=1,R=0 set to 1; S=0,R=1 clear to 0; S=1,R=1 per MODE.
REQ-019 ld=1 SHALL load q<=d on all channels, overriding s and r.
REQ-020 A conflict SHALL be detected on channel i when s[i]=r[i]=1 and ld=0; with ld=1, conflicts are not detected.
REQ-021 A detected conflict SHALL set conflict[i] on the next edge, and conflict[i] SHALL stay set until clr_conflict or reset.
REQ-022 conflict_cnt SHALL increment by 1 per cycle with any conflict, not per channel, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 clr_conflict=1 with no conflict in the same cycle SHALL set conflict to 0 and conflict_cnt to 0.
REQ-024 clr_conflict=1 together with a new conflict SHALL leave only the new conflicting channels flagged and SHALL set conflict_cnt to 1; the new event wins.
REQ-025 Channels SHALL be fully independent; activity on one channel SHALL NOT affect q of another.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL set q=RESET_VAL, qn=~RESET_VAL, conflict=0 and conflict_cnt=0.
REQ-027 Reset SHALL have priority over ld, s, r and clr_conflict.
REQ-028 A conflict sampled in the same cycle as reset SHALL NOT be recorded.
REQ-029 Operation SHALL resume on the first edge with rst_n=1.

Structure
REQ-030 Shared package sr_pkg SHALL hold the MODE encodings (MODE_SET_DOM, MODE_RST_DOM, MODE_HOLD, MODE_TOGGLE) and the next-state function.
REQ-031 A per-channel sub-module sr_cell, holding one state bit and its conflict flag, SHALL be instantiated WIDTH times through a generate loop.
REQ-032 The conflict counter and the reduction of per-channel conflicts SHALL live in sr_bank.

Verification
REQ-033 WIDTH=4, RESET_VAL=4'b1010: hold rst_n=0 for 2 cycles -> q=1010, qn=0101, conflict=0, conflict_cnt=0.
REQ-034 Exhaustive sweep of s[0],r[0] in {00,10,01,00}, each for 1 cycle with pulses between -> q[0] follows 0,1,0,0 (held) one edge later; other channels unchanged.
REQ-035 Run each MODE 0..3 with s=r=4'b0001 for 2 cycles from q[0]=0 -> q[0] is 1,1 / 0,0 / 0,0 / 1,0; conflict[0]=1; conflict_cnt=2.
REQ-036 CNT_W=2 with a conflict held for 5 cycles -> conflict_cnt reads 1,2,3,3,3.
REQ-037 ld=1, d=4'b0110 with s=r=4'b1111 -> q=0110 and no conflict recorded; then clr_conflict together with a new conflict on channel 2 -> conflict=0100, conflict_cnt=1.
REQ-038 Assert rst_n=0 in the middle of a conflict/toggle sequence -> next edge shows q=RESET_VAL, counter 0, and q==~qn checked every cycle.

Source files
------------

// File: rtl/sr_pkg.sv
// sr_pkg: shared definitions for the SR bank.
//   MODE_* : encodings selecting the response of a channel to S=R=1.
//   sr_next: next-state function for one channel (load handled by the caller).
package sr_pkg;

    localparam logic [1:0] MODE_SET_DOM = 2'd0;
    localparam logic [1:0] MODE_RST_DOM = 2'd1;
    localparam logic [1:0] MODE_HOLD    = 2'd2;
    localparam logic [1:0] MODE_TOGGLE  = 2'd3;

    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input logic [1:0] mode);
        logic nq;
        nq = q;
        unique case ({s, r})
            2'b00: nq = q;
            2'b10: nq = 1'b1;
            2'b01: nq = 1'b0;
            default: begin
                unique case (mode)
                    MODE_SET_DOM: nq = 1'b1;
                    MODE_RST_DOM: nq = 1'b0;
                    MODE_HOLD:    nq = q;
                    default:      nq = ~q;
                endcase
            end
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/sr_cell.sv
// sr_cell: one SR channel -- a state bit plus its sticky conflict flag.
//   clk, rst_n    : clock, synchronous active-low reset
//   rst_val       : value loaded into q on reset
//   s, r          : set / reset requests
//   ld, d         : parallel load strobe and data bit (load overrides s/r)
//   clr_conflict  : clears the sticky flag unless a new conflict arrives
//   q             : registered state
//   conflict      : sticky flag, set one edge after S=R=1 was seen with ld=0
//   hit           : combinational conflict detect, reduced by the bank counter
module sr_cell
    import sr_pkg::*;
#(
    parameter int MODE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic s,
    input  logic r,
    input  logic ld,
    input  logic d,
    input  logic clr_conflict,
    output logic q,
    output logic conflict,
    output logic hit
);

    localparam logic [1:0] MODE_L = MODE[1:0];

    logic q_d, q_q;
    logic conflict_d, conflict_q;

    // A load masks the conflict: s/r are ignored that cycle.
    assign hit = s & r & ~ld;

    always_comb begin
        q_d        = ld ? d : sr_next(q_q, s, r, MODE_L);
        // A new conflict wins over a simultaneous clear.
        conflict_d = conflict_q;
        if (hit)
            conflict_d = 1'b1;
        else if (clr_conflict)
            conflict_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q        <= rst_val;
            conflict_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            conflict_q <= conflict_d;
        end
    end

    assign q        = q_q;
    assign conflict = conflict_q;

endmodule

// File: rtl/sr_bank.sv
// sr_bank: WIDTH independent SR channels with conflict tracking.
//   clk, rst_n        : clock, synchronous active-low reset
//   s, r [WIDTH]      : per-channel set / reset requests
//   ld, d [WIDTH]     : parallel load strobe / data
//   clr_conflict      : clears conflict flags and counter
//   q, qn [WIDTH]     : registered state and its complement
//   conflict [WIDTH]  : sticky per-channel S=R=1 flags
//   conflict_cnt      : saturating count of cycles with any conflict
module sr_bank
    import sr_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               MODE      = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_conflict,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic [WIDTH-1:0] hit;
    logic             any_hit;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(.MODE(MODE)) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .rst_val     (RESET_VAL[i]),
            .s           (s[i]),
            .r           (r[i]),
            .ld          (ld),
            .d           (d[i]),
            .clr_conflict(clr_conflict),
            .q           (q[i]),
            .conflict    (conflict[i]),
            .hit         (hit[i])
        );
    end

    // qn comes straight off the state flops so it can never disagree with q.
    assign qn      = ~q;
    assign any_hit = |hit;

    // Counts cycles, not channels; a clear coinciding with a conflict restarts at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (any_hit) begin
            if (clr_conflict)
                cnt_d = CNT_W'(1);
            else if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + CNT_W'(1);
        end else if (clr_conflict) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_bank.sv
module tb_sr_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       ld = 1'b0, clr = 1'b0;
    logic [3:0] s = 4'h0, r = 4'h0, d = 4'h0;

    logic [3:0] q_o[4], qn_o[4], c_o[4];
    logic [7:0] cnt_o[4];
    logic [3:0] q_s, qn_s, c_s;
    logic [1:0] cnt_s;

    // DUTs 0..3: MODE 0..3; DUT 4: MODE 0 with a 2-bit counter.
    for (genvar m = 0; m < 4; m++) begin : g_dut
        sr_bank #(.WIDTH(4), .MODE(m), .RESET_VAL(4'b1010), .CNT_W(8)) u_dut (
            .clk(clk), .rst_n(rst_n), .s(s), .r(r), .ld(ld), .d(d),
            .clr_conflict(clr), .q(q_o[m]), .qn(qn_o[m]), .conflict(c_o[m]),
            .conflict_cnt(cnt_o[m]));
    end

    sr_bank #(.WIDTH(4), .MODE(0), .RESET_VAL(4'b1010), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .s(s), .r(r), .ld(ld), .d(d),
        .clr_conflict(clr), .q(q_s), .qn(qn_s), .conflict(c_s),
        .conflict_cnt(cnt_s));

    int n_cmp = 0, n_err = 0;

    // Reference model state, one entry per DUT.
    int         mode_k[5] = '{0, 1, 2, 3, 0};
    int         cmax_k[5] = '{255, 255, 255, 255, 3};
    logic [3:0] mq[5], mc[5];
    int         mcnt[5];

    // Sampled DUT outputs.
    logic [3:0] aq[5], aqn[5], ac[5];
    logic [7:0] acnt[5];

    // Advance one edge: update the model from the inputs seen at that edge,
    // then sample every DUT shortly after it.
    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            if (!rst_n) begin
                mq[k] = 4'b1010; mc[k] = 4'h0; mcnt[k] = 0;
            end else begin
                logic [3:0] hits;
                if (ld) mq[k] = d;
                else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s[b] && !r[b])      mq[k][b] = 1'b1;
                        else if (!s[b] && r[b]) mq[k][b] = 1'b0;
                        else if (s[b] && r[b]) begin
                            case (mode_k[k])
                                0: mq[k][b] = 1'b1;
                                1: mq[k][b] = 1'b0;
                                2: mq[k][b] = mq[k][b];
                                default: mq[k][b] = ~mq[k][b];
                            endcase
                        end
                    end
                end
                hits = ld ? 4'h0 : (s & r);
                mc[k] = hits | (clr ? 4'h0 : mc[k]);
                if (hits != 4'h0) mcnt[k] = clr ? 1 : (mcnt[k] < cmax_k[k] ? mcnt[k] + 1 : mcnt[k]);
                else if (clr) mcnt[k] = 0;
            end
        end
        #1;
        for (int k = 0; k < 4; k++) begin
            aq[k] = q_o[k]; aqn[k] = qn_o[k]; ac[k] = c_o[k]; acnt[k] = cnt_o[k];
        end
        aq[4] = q_s; aqn[4] = qn_s; ac[4] = c_s; acnt[4] = {6'd0, cnt_s};
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s = 4'hF; r = 4'hF; ld = 1'b0; clr = 1'b0; d = 4'h0;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                n_cmp += 4;
                if (aq[k] !== 4'b1010) begin n_err++; $display("FAIL reset_q dut%0d got %b exp 1010", k, aq[k]); end
                if (aqn[k] !== 4'b0101) begin n_err++; $display("FAIL reset_qn dut%0d got %b exp 0101", k, aqn[k]); end
                if (ac[k] !== 4'h0) begin n_err++; $display("FAIL reset_conflict dut%0d got %b exp 0000", k, ac[k]); end
                if (acnt[k] !== 8'd0) begin n_err++; $display("FAIL reset_cnt dut%0d got %0d exp 0", k, acnt[k]); end
            end
        end
        s = 4'h0; r = 4'h0;
    endtask

    task automatic test_sweep();
        logic [1:0] pat[4] = '{2'b00, 2'b10, 2'b01, 2'b00};
        logic       exp0[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = {3'b000, pat[i][1]}; r = {3'b000, pat[i][0]};
            step();
            s = 4'h0; r = 4'h0;
            n_cmp += 2;
            if (aq[0][0] !== exp0[i]) begin n_err++; $display("FAIL sweep_q0 step%0d got %b exp %b", i, aq[0][0], exp0[i]); end
            if (aq[0][3:1] !== 3'b101) begin n_err++; $display("FAIL sweep_other step%0d got %b exp 101", i, aq[0][3:1]); end
            for (int k = 0; k < 5; k++) begin
                n_cmp += 2;
                if (aq[k] !== mq[k]) begin n_err++; $display("FAIL sweep_model_q dut%0d got %b exp %b", k, aq[k], mq[k]); end
                if (aqn[k] !== ~mq[k]) begin n_err++; $display("FAIL sweep_qn dut%0d got %b exp %b", k, aqn[k], ~mq[k]); end
            end
        end
    endtask

    task automatic test_modes();
        logic exp_q[4][2] = '{'{1'b1, 1'b1}, '{1'b0, 1'b0}, '{1'b0, 1'b0}, '{1'b1, 1'b0}};
        rst_n = 1'b0; step(); rst_n = 1'b1;
        s = 4'b0001; r = 4'b0001;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int m = 0; m < 4; m++) begin
                n_cmp++;
                if (aq[m][0] !== exp_q[m][c]) begin n_err++; $display("FAIL mode%0d_q0 cyc%0d got %b exp %b", m, c, aq[m][0], exp_q[m][c]); end
            end
        end
        s = 4'h0; r = 4'h0;
        for (int k = 0; k < 5; k++) begin
            n_cmp += 3;
            if (ac[k] !== 4'b0001) begin n_err++; $display("FAIL mode_conflict dut%0d got %b exp 0001", k, ac[k]); end
            if (acnt[k] !== 8'd2) begin n_err++; $display("FAIL mode_cnt dut%0d got %0d exp 2", k, acnt[k]); end
            if (aqn[k] !== ~mq[k]) begin n_err++; $display("FAIL mode_qn dut%0d got %b exp %b", k, aqn[k], ~mq[k]); end
        end
    endtask

    task automatic test_saturate();
        int exp_cnt[5] = '{1, 2, 3, 3, 3};
        rst_n = 1'b0; step(); rst_n = 1'b1;
        s = 4'b0010; r = 4'b0010;
        for (int c = 0; c < 5; c++) begin
            step();
            n_cmp += 2;
            if (acnt[4] !== 8'(exp_cnt[c])) begin n_err++; $display("FAIL sat_cnt cyc%0d got %0d exp %0d", c, acnt[4], exp_cnt[c]); end
            if (acnt[0] !== 8'(c + 1)) begin n_err++; $display("FAIL wide_cnt cyc%0d got %0d exp %0d", c, acnt[0], c + 1); end
        end
        s = 4'h0; r = 4'h0;
    endtask

    task automatic test_load_clr();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        s = 4'b1000; r = 4'b1000; step();
        ld = 1'b1; d = 4'b0110; s = 4'hF; r = 4'hF; step();
        ld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp += 3;
            if (aq[k] !== 4'b0110) begin n_err++; $display("FAIL load_q dut%0d got %b exp 0110", k, aq[k]); end
            if (ac[k] !== 4'b1000) begin n_err++; $display("FAIL load_conflict dut%0d got %b exp 1000", k, ac[k]); end
            if (acnt[k] !== 8'd1) begin n_err++; $display("FAIL load_cnt dut%0d got %0d exp 1", k, acnt[k]); end
        end
        clr = 1'b1; s = 4'b0100; r = 4'b0100; step();
        clr = 1'b0; s = 4'h0; r = 4'h0;
        for (int k = 0; k < 5; k++) begin
            n_cmp += 3;
            if (ac[k] !== 4'b0100) begin n_err++; $display("FAIL clr_conflict dut%0d got %b exp 0100", k, ac[k]); end
            if (acnt[k] !== 8'd1) begin n_err++; $display("FAIL clr_cnt dut%0d got %0d exp 1", k, acnt[k]); end
            if (aq[k] !== mq[k]) begin n_err++; $display("FAIL clr_q dut%0d got %b exp %b", k, aq[k], mq[k]); end
        end
        clr = 1'b1; step(); clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp += 2;
            if (ac[k] !== 4'h0) begin n_err++; $display("FAIL clr_only_conflict dut%0d got %b exp 0000", k, ac[k]); end
            if (acnt[k] !== 8'd0) begin n_err++; $display("FAIL clr_only_cnt dut%0d got %0d exp 0", k, acnt[k]); end
        end
    endtask

    task automatic test_reset_mid();
        rst_n = 1'b1; s = 4'hF; r = 4'hF;
        for (int c = 0; c < 3; c++) begin
            step();
            for (int k = 0; k < 5; k++) begin
                n_cmp += 2;
                if (aq[k] !== mq[k]) begin n_err++; $display("FAIL mid_q dut%0d got %b exp %b", k, aq[k], mq[k]); end
                if (aqn[k] !== ~aq[k] || aqn[k] !== ~mq[k]) begin n_err++; $display("FAIL mid_qn dut%0d got %b exp %b", k, aqn[k], ~mq[k]); end
            end
        end
        rst_n = 1'b0; clr = 1'b0; step();
        rst_n = 1'b1; s = 4'h0; r = 4'h0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 5; k++) begin
                n_cmp += 4;
                if (aq[k] !== 4'b1010) begin n_err++; $display("FAIL midrst_q dut%0d got %b exp 1010", k, aq[k]); end
                if (aqn[k] !== 4'b0101) begin n_err++; $display("FAIL midrst_qn dut%0d got %b exp 0101", k, aqn[k]); end
                if (ac[k] !== 4'h0) begin n_err++; $display("FAIL midrst_conflict dut%0d got %b exp 0000", k, ac[k]); end
                if (acnt[k] !== 8'd0) begin n_err++; $display("FAIL midrst_cnt dut%0d got %0d exp 0", k, acnt[k]); end
            end
            step();
        end
    endtask

    task automatic test_random();
        rst_n = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            ld    = ($urandom_range(0, 7) == 0);
            clr   = ($urandom_range(0, 9) == 0);
            s     = 4'($urandom);
            r     = 4'($urandom);
            d     = 4'($urandom);
            step();
            for (int k = 0; k < 5; k++) begin
                n_cmp += 4;
                if (aq[k] !== mq[k]) begin n_err++; $display("FAIL rand_q cyc%0d dut%0d got %b exp %b", c, k, aq[k], mq[k]); end
                if (aqn[k] !== ~mq[k]) begin n_err++; $display("FAIL rand_qn cyc%0d dut%0d got %b exp %b", c, k, aqn[k], ~mq[k]); end
                if (ac[k] !== mc[k]) begin n_err++; $display("FAIL rand_conflict cyc%0d dut%0d got %b exp %b", c, k, ac[k], mc[k]); end
                if (acnt[k] !== 8'(mcnt[k])) begin n_err++; $display("FAIL rand_cnt cyc%0d dut%0d got %0d exp %0d", c, k, acnt[k], mcnt[k]); end
            end
        end
        rst_n = 1'b1; ld = 1'b0; clr = 1'b0; s = 4'h0; r = 4'h0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sweep();
        test_modes();
        test_saturate();
        test_load_clr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
